// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator.
// Free-running h/v counters produce stage-0 pixel coordinates and the
// active-video flag for the picture stage. Sync and blanking are delayed
// through a PIPE_DLY-deep shift register so they line up with the colour
// returned by the picture stage, then registered once more at the output.
module vga_timing_ctrl #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned PIPE_DLY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] rgb_in,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        video_on,
   output logic        frame_tick,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb_out
);

   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        h_wrap;
   logic        hs_0, vs_0;
   logic        de_d, hs_d, vs_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic [11:0] rgb_out_q, rgb_out_d;

   // Next-state for the raster counters; >= on wrap so any stray value recovers.
   always_comb begin
      h_wrap  = (h_cnt_q >= H_LAST);
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = (v_cnt_q >= V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
   end

   // Raster counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Stage-0 decode straight from the counter registers (no added latency).
   always_comb begin
      video_on   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      pix_x      = (h_cnt_q < H_ACT) ? h_cnt_q : '0;
      pix_y      = (v_cnt_q < V_ACT) ? v_cnt_q[8:0] : '0;
      hs_0       = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
      vs_0       = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
      frame_tick = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
   end

   // Delay line matching the picture-stage latency; PIPE_DLY=0 is a pass-through.
   if (PIPE_DLY > 0) begin : g_pipe
      logic [PIPE_DLY-1:0] de_sr_q, de_sr_d;
      logic [PIPE_DLY-1:0] hs_sr_q, hs_sr_d;
      logic [PIPE_DLY-1:0] vs_sr_q, vs_sr_d;
      logic [PIPE_DLY:0]   de_sh, hs_sh, vs_sh;

      // Shift stage-0 flags in at bit 0.
      always_comb begin
         de_sh   = {de_sr_q, video_on};
         hs_sh   = {hs_sr_q, hs_0};
         vs_sh   = {vs_sr_q, vs_0};
         de_sr_d = de_sh[PIPE_DLY-1:0];
         hs_sr_d = hs_sh[PIPE_DLY-1:0];
         vs_sr_d = vs_sh[PIPE_DLY-1:0];
      end

      // Shift-register stages reset to blanked, syncs inactive.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            de_sr_q <= '0;
            hs_sr_q <= '1;
            vs_sr_q <= '1;
         end else begin
            de_sr_q <= de_sr_d;
            hs_sr_q <= hs_sr_d;
            vs_sr_q <= vs_sr_d;
         end
      end

      assign de_d = de_sr_q[PIPE_DLY-1];
      assign hs_d = hs_sr_q[PIPE_DLY-1];
      assign vs_d = vs_sr_q[PIPE_DLY-1];
   end else begin : g_nopipe
      assign de_d = video_on;
      assign hs_d = hs_0;
      assign vs_d = vs_0;
   end

   // Output register inputs; colour forced to black outside the active area.
   always_comb begin
      hsync_d   = hs_d;
      vsync_d   = vs_d;
      rgb_out_d = de_d ? rgb_in : '0;
   end

   // Output registers towards the connector / DAC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         rgb_out_q <= '0;
      end else begin
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         rgb_out_q <= rgb_out_d;
      end
   end

   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
   assign rgb_out = rgb_out_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized self-checking bench for vga_timing_ctrl.
// Uses a shrunken raster so several frames fit in a short run. The model
// derives every expected output from the elapsed cycle count since reset
// release using plain division/modulo arithmetic.
module tb_vga_timing_ctrl;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
   localparam int P  = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] rgb_in = '0;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        video_on;
   logic        frame_tick;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb_out;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          t = 0;
   logic [11:0] last_rgb = '0;
   bit          fff_mode = 1'b0;
   int          cnt_fff = 0;

   vga_timing_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .PIPE_DLY(P)
   ) dut (
      .clk(clk), .rst(rst), .rgb_in(rgb_in),
      .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
      .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
      end
   endtask

   function automatic int h_of(input int k);
      return k % HT;
   endfunction

   function automatic int v_of(input int k);
      return (k / HT) % VT;
   endfunction

   function automatic bit active(input int k);
      return (h_of(k) < HA) && (v_of(k) < VA);
   endfunction

   function automatic bit hs_raw(input int k);
      return !((h_of(k) >= HA + HF) && (h_of(k) < HA + HF + HS));
   endfunction

   function automatic bit vs_raw(input int k);
      return !((v_of(k) >= VA + VF) && (v_of(k) < VA + VF + VS));
   endfunction

   // Outputs expected while rst is asserted.
   task automatic check_reset(input string tag);
      check_eq({tag, "_pix_x"},    32'(pix_x),      32'd0);
      check_eq({tag, "_pix_y"},    32'(pix_y),      32'd0);
      check_eq({tag, "_video_on"}, 32'(video_on),   32'd1);
      check_eq({tag, "_tick"},     32'(frame_tick), 32'd0);
      check_eq({tag, "_hsync"},    32'(hsync),      32'd1);
      check_eq({tag, "_vsync"},    32'(vsync),      32'd1);
      check_eq({tag, "_rgb"},      32'(rgb_out),    32'd0);
   endtask

   // Compare every output against the model for elapsed cycle count t.
   task automatic check_all();
      int  h, v, lag;
      bit  exp_hs, exp_vs;
      logic [11:0] exp_rgb;
      h   = h_of(t);
      v   = v_of(t);
      lag = t - P - 1;
      exp_hs  = (lag >= 0) ? hs_raw(lag) : 1'b1;
      exp_vs  = (lag >= 0) ? vs_raw(lag) : 1'b1;
      exp_rgb = (lag >= 0 && active(lag)) ? last_rgb : 12'h000;
      check_eq("pix_x",    32'(pix_x),      (h < HA) ? 32'(h) : 32'd0);
      check_eq("pix_y",    32'(pix_y),      (v < VA) ? 32'(v) : 32'd0);
      check_eq("video_on", 32'(video_on),   32'((h < HA) && (v < VA)));
      check_eq("tick",     32'(frame_tick), 32'((h == 0) && (v == VA)));
      check_eq("hsync",    32'(hsync),      32'(exp_hs));
      check_eq("vsync",    32'(vsync),      32'(exp_vs));
      check_eq("rgb_out",  32'(rgb_out),    32'(exp_rgb));
      if (rgb_out == 12'hFFF) cnt_fff++;
   endtask

   task automatic drive_rgb();
      rgb_in   = fff_mode ? 12'hFFF : 12'($urandom);
      last_rgb = rgb_in;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         t++;
         @(negedge clk);
         check_all();
         drive_rgb();
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      t   = 0;
      check_all();
      drive_rgb();
   endtask

   initial begin
      int budget;
      drive_rgb();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("rst0");

      release_reset();
      run_cycles(2 * FT + 37);

      // Seek a mid-frame point, then assert reset between clock edges.
      budget = 2 * FT;
      while (!(v_of(t) == 4 && h_of(t) == 7) && budget > 0) begin
         run_cycles(1);
         budget--;
      end
      check_eq("seek_budget", 32'(budget > 0), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset("async");
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_reset("hold");

      release_reset();
      run_cycles(FT + 11);

      // Constant white input: exactly one active area's worth per frame.
      fff_mode = 1'b1;
      run_cycles(P + 2);
      cnt_fff = 0;
      run_cycles(FT);
      check_eq("fff_count", 32'(cnt_fff), 32'(HA * VA));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
